// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one multiplier, shared coefficients, per-channel delay lines.
// Optional macro FIR_SAT_EN selects output saturation; otherwise the output wraps.
module fir_filter_mc #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 16,
  parameter int NCH    = 2,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TAP_W = $clog2(NTAPS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  input  logic signed [DATA_W-1:0] s_axis_data_tdata,
  input  logic [CH_W-1:0]          s_axis_data_tuser,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic signed [OUT_W-1:0]  m_axis_data_tdata,
  output logic [CH_W-1:0]          m_axis_data_tuser,
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + TAP_W;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [DATA_W-1:0] dline [NCH][NTAPS];

  logic [TAP_W-1:0]         tap_p0;
  logic [CH_W-1:0]          ch_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  data_p2;
  logic [CH_W-1:0]          ch_p2;
  logic                     vld_p2;
  logic                     err_p1;

  logic accept;
  logic ch_ok;
  logic mac_last;
  logic out_fire;

  // Shift then reduce to OUT_W; saturating or wrapping depending on build.
  function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
`ifdef FIR_SAT_EN
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [EXT_W-1:0] ext;
    sh  = a >>> SHIFT;
    ext = EXT_W'(sh);
    if (ext > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (ext < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end
    return ext[OUT_W-1:0];
`else
    sh = a >>> SHIFT;
    return OUT_W'(sh);
`endif
  endfunction

  assign s_axis_data_tready = (state == IDLE) && !areset;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign ch_ok              = int'(s_axis_data_tuser) < NCH;
  assign mac_last           = (state == MAC) && (tap_p0 == TAP_W'(NTAPS - 1));
  assign out_fire           = (state == OUT) && m_axis_data_tready;

  assign m_axis_data_tvalid = vld_p2;
  assign m_axis_data_tdata  = data_p2;
  assign m_axis_data_tuser  = ch_p2;
  assign coef_err           = err_p1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && ch_ok) state_nxt = MAC;
      MAC:     if (mac_last)        state_nxt = OUT;
      OUT:     if (m_axis_data_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficients are writable only while idle; a write landing on the accept edge is seen by that MAC.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
      err_p1 <= 1'b0;
    end else begin
      if (coef_we && (state == IDLE) && (int'(coef_addr) < NTAPS)) begin
        coef[coef_addr] <= coef_data;
      end
      err_p1 <= coef_we && (state != IDLE);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NTAPS; k++) dline[c][k] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (accept && ch_ok && (c == int'(s_axis_data_tuser))) begin
          dline[c][0] <= s_axis_data_tdata;
          for (int k = 1; k < NTAPS; k++) dline[c][k] <= dline[c][k-1];
        end
      end
    end
  end

  // Stage p0: one tap product per MAC cycle.
  assign prod_p0 = PROD_W'(coef[tap_p0]) * PROD_W'(dline[ch_p0][tap_p0]);
  assign acc_sum = acc_p1 + ACC_W'(prod_p0);

  // Stage p1: accumulate; stage p2: reduced result held until the handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tap_p0  <= '0;
      ch_p0   <= '0;
      acc_p1  <= '0;
      data_p2 <= '0;
      ch_p2   <= '0;
      vld_p2  <= 1'b0;
    end else begin
      if (accept && ch_ok) begin
        tap_p0 <= '0;
        ch_p0  <= s_axis_data_tuser;
        acc_p1 <= '0;
      end
      if (state == MAC) begin
        tap_p0 <= tap_p0 + 1'b1;
        acc_p1 <= acc_sum;
        if (mac_last) begin
          data_p2 <= reduce_out(acc_sum);
          ch_p2   <= ch_p0;
          vld_p2  <= 1'b1;
        end
      end
      if (out_fire) begin
        vld_p2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench for fir_filter_mc: NTAPS=4, NCH=2, 16-bit data/coef/out, SHIFT=0.
module tb_fir_filter_mc;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 4;
  localparam int NCH    = 2;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 0;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_tvalid, s_tready;
  logic [15:0] s_tdata;
  logic        s_tuser;
  logic        m_tvalid, m_tready;
  logic [15:0] m_tdata;
  logic        m_tuser;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_err;

  typedef struct {
    int          ch;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   acc_idx = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   vld_prev = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  fir_filter_mc #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS),
    .NCH(NCH), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tuser  (s_tuser),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tuser  (m_tuser),
    .coef_we            (coef_we),
    .coef_addr          (coef_addr),
    .coef_data          (coef_data),
    .coef_err           (coef_err)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Monitor: latency of each rising valid, and scoreboard pop on every handshake.
  always @(negedge aclk) begin
    exp_t e;
    if (m_tvalid && !vld_prev) check("latency", cyc - acc_idx, 5);
    vld_prev = m_tvalid;
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        check("spurious_output", int'(m_tvalid), 0);
      end else begin
        e = q.pop_front();
        n_pop++;
        check("out_data", m_tdata, e.d);
        check("out_user", m_tuser, e.ch);
      end
    end
  end

  task automatic write_coef(input int addr, input int val);
    @(negedge aclk);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = 16'(val);
    @(posedge aclk);
    #1 coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input int data, input bit push, input logic [15:0] exp,
                      input bit we = 1'b0, input int addr = 0, input int cd = 0);
    exp_t e;
    int   n;
    @(negedge aclk);
    s_tvalid  = 1'b1;
    s_tdata   = 16'(data);
    s_tuser   = ch[0];
    coef_we   = we;
    coef_addr = 2'(addr);
    coef_data = 16'(cd);
    n = 0;
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("accept_in_time", int'(n < 200), 1);
    acc_idx = cyc;
    if (push) begin
      e.ch = ch;
      e.d  = exp;
      q.push_back(e);
      n_push++;
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !s_tready) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    check("drain_in_time", int'(n < 500), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_bad++;
    summary();
    $finish;
  end

  initial begin
    int n;
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0;
    m_tready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge aclk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_s_tready", s_tready, 0);
    areset = 1'b0;
    #1 check("tready_after_reset", s_tready, 1);

    // Impulse response on ch0 with c = 1,2,3,4.
    for (int k = 0; k < 4; k++) write_coef(k, k + 1);
    send(0, 100, 1, 16'd100);
    send(0, 0,   1, 16'd200);
    send(0, 0,   1, 16'd300);
    send(0, 0,   1, 16'd400);
    drain();

    // Interleaved channels.
    send(0, 100, 1, 16'd100); send(1, 7, 1, 16'd7);
    send(0, 0,   1, 16'd200); send(1, 7, 1, 16'd21);
    send(0, 0,   1, 16'd300); send(1, 7, 1, 16'd42);
    send(0, 0,   1, 16'd400); send(1, 7, 1, 16'd70);
    drain();

    // Back-pressure: ch1 x = [5,7,7,7] -> 5+14+21+28 = 68.
    m_tready = 1'b0;
    send(1, 5, 1, 16'd68);
    n = 0;
    while (!m_tvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("bp_valid_seen", m_tvalid, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check("bp_tdata_hold", m_tdata, 68);
      check("bp_tuser_hold", m_tuser, 1);
      check("bp_tvalid_hold", m_tvalid, 1);
      check("bp_s_tready_low", s_tready, 0);
    end
    @(posedge aclk);
    #1 m_tready = 1'b1;
    drain();

    // Coefficient write during MAC is rejected: x = [1,5,7,7] -> 60 with old c.
    send(1, 1, 1, 16'd60);
    @(negedge aclk);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd50;
    @(posedge aclk);
    #1 coef_we = 1'b0;
    @(negedge aclk);
    check("coef_err_pulse", coef_err, 1);
    @(negedge aclk);
    check("coef_err_single", coef_err, 0);
    drain();
    send(1, 2, 1, 16'd47);
    drain();

    // Same-cycle accept and coefficient write: c0=10, x = [3,2,1,5] -> 30+4+3+20 = 57.
    send(1, 3, 1, 16'd57, 1'b1, 0, 10);
    drain();

    // Reset mid-MAC aborts with no output.
    send(0, 9, 0, 16'd0);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check("abort_m_tvalid", m_tvalid, 0);
    check("abort_m_tdata", m_tdata, 0);
    check("abort_m_tuser", m_tuser, 0);
    check("abort_s_tready", s_tready, 0);
    check("abort_coef_err", coef_err, 0);
    areset = 1'b0;
    #1 check("abort_tready_release", s_tready, 1);
    repeat (12) @(negedge aclk);
    check("abort_no_output", m_tvalid, 0);

    // Full-scale: c = 32767 x4 on ch0, then negative extremes on ch1.
    for (int k = 0; k < 4; k++) write_coef(k, 32767);
`ifdef FIR_SAT_EN
    send(0, 32767, 1, 16'h7FFF); send(0, 32767, 1, 16'h7FFF);
    send(0, 32767, 1, 16'h7FFF); send(0, 32767, 1, 16'h7FFF);
    send(1, -32768, 1, 16'h8000); send(1, -32768, 1, 16'h8000);
`else
    send(0, 32767, 1, 16'h0001); send(0, 32767, 1, 16'h0002);
    send(0, 32767, 1, 16'h0003); send(0, 32767, 1, 16'h0004);
    send(1, -32768, 1, 16'h8000); send(1, -32768, 1, 16'h0000);
`endif
    drain();

    check("queue_empty", q.size(), 0);
    check("transfer_count", n_pop, n_push);
    summary();
    $finish;
  end

endmodule
